bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter DIGITS SHALL default to 4 and specify the number of BCD digits per operand; the legal range is 1..16.
REQ-002 in_clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 in_rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 in_start  input  1  SHALL be the operation request, sampled only in IDLE.
REQ-005 in_sub  input  1  SHALL select the mode: 0 = A+B, 1 = A-B.
REQ-006 in_a  input  4*DIGITS  SHALL be operand A in packed BCD, digit 0 (least significant) at [3:0].
REQ-007 in_b  input  4*DIGITS  SHALL be operand B in the same packing as in_a.
REQ-008 out_busy  output  1  SHALL be high while digits are being processed.
REQ-009 out_done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 out_result  output  4*DIGITS  SHALL be the packed BCD result.
REQ-011 out_carry  output  1  SHALL report, in add mode, carry out of the MSD; in subtract mode, no-borrow (1 = A>=B).
REQ-012 out_error  output  1  SHALL report that a captured operand held a digit above 9.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with in_start=1 at an edge, the block SHALL:
- capture in_a, in_b and in_sub;
- clear the result register and set digit index to 0;
- set internal carry to in_sub;
- register out_error from a check of both operands;
- enter RUN.
REQ-015 in_start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change until the next acceptance.
REQ-016 In RUN, each edge SHALL process one digit d (d = 0 first):
- b' = in_sub ? 9-b_d : b_d;
- s = a_d + b' + c (5-bit);
- s>9 gives result digit s-10 and c=1; otherwise result digit s and c=0.
REQ-017 The edge that processes digit DIGITS-1 SHALL latch the final c into out_carry and move the FSM to DONE.
REQ-018 out_busy SHALL be 1 exactly while in RUN, i.e. for DIGITS cycles after acceptance.
REQ-019 out_done SHALL be 1 exactly while in DONE: one cycle, beginning DIGITS edges after the accepting edge.
REQ-020 DONE SHALL return unconditionally to IDLE on the next edge; the minimum start-to-start spacing is therefore DIGITS+2 cycles.
REQ-021 In add mode, out_result SHALL equal (A+B) mod 10^DIGITS, and out_carry=1 iff A+B > 10^DIGITS-1.
REQ-022 In subtract mode with A>=B, the block SHALL output out_result = A-B and out_carry=1.
REQ-023 In subtract mode with A<B, the block SHALL output out_result = 10^DIGITS-(B-A) (ten's complement) and out_carry=0.
REQ-024 If any captured digit of A or B exceeds 9:
- the operation SHALL still take the full latency;
- at out_done, out_error SHALL be 1, out_result SHALL be all zeros and out_carry SHALL be 0.
REQ-025 out_result, out_carry and out_error SHALL hold their values from DONE until the next accepted in_start.
REQ-026 out_result digits already written SHALL NOT be required to be stable or meaningful during RUN; consumers SHALL qualify out_result with out_done.

Reset
REQ-027 When in_rst_n=0, the block SHALL asynchronously force:
- FSM to IDLE; digit index and internal carry to 0;
- out_busy=0, out_done=0, out_result=0, out_carry=0, out_error=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no out_done pulse.
REQ-029 After reset release, the first in_start seen in IDLE SHALL be accepted normally.

Verification (DIGITS=4 unless stated)
REQ-030 add 1234+5678 -> out_result=6912, out_carry=0; out_done exactly 4 edges after acceptance; out_busy high for 4 cycles.
REQ-031 add 9999+0001 -> out_result=0000, out_carry=1.
REQ-032 subtract 0500-0123 -> out_result=0377, out_carry=1.
REQ-033 subtract 0123-0500 -> out_result=9623, out_carry=0.
REQ-034 A=12A4 (digit 10), B=0001, add -> out_error=1, out_result=0000, out_carry=0 at out_done.
REQ-035 in_start re-pulsed during RUN with new operands -> ignored, first result unchanged.
REQ-036 in_rst_n pulsed low mid-RUN -> outputs 0 immediately, no out_done; then 0001+0002 -> 0003.
REQ-037 With DIGITS=1, add 9+9 -> out_result=8, out_carry=1, out_done 1 edge after acceptance.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor.
// One BCD digit is processed per clock, least significant digit first.
// Subtraction uses the nine's complement of B with an initial carry of 1,
// so the final carry reads as "no borrow" (A >= B).
// Handshake: in_start is honoured only in IDLE. The result is valid while
// out_done is high and holds until the next accepted in_start. out_busy
// marks the DIGITS cycles in which digits are processed.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_start,
    input  logic                  in_sub,
    input  logic [4*DIGITS-1:0]   in_a,
    input  logic [4*DIGITS-1:0]   in_b,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [4*DIGITS-1:0]   out_result,
    output logic                  out_carry,
    output logic                  out_error,
    output logic [1:0]            out_state
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [IW-1:0]   idx_q,    idx_d;
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic            sub_q,    sub_d;
    logic            c_q,      c_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q,  carry_d;
    logic            error_q,  error_d;

    // Per-digit datapath signals
    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      b_eff;
    logic [4:0]      sum;
    logic [4:0]      sum_adj;
    logic [3:0]      dig_out;
    logic            dig_cout;

    // True when any nibble of the operand is not a valid BCD digit
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One BCD digit step: optional nine's complement of B, add, decimal adjust
    always_comb begin
        a_dig    = a_q[int'(idx_q)*4 +: 4];
        b_dig    = b_q[int'(idx_q)*4 +: 4];
        b_eff    = sub_q ? (4'd9 - b_dig) : b_dig;
        sum      = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, c_q};
        sum_adj  = sum - 5'd10;
        dig_out  = sum[3:0];
        dig_cout = 1'b0;
        if (sum > 5'd9) begin
            dig_out  = sum_adj[3:0];
            dig_cout = 1'b1;
        end
    end

    // Next-state and datapath register control for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        c_d      = c_q;
        result_d = result_q;
        carry_d  = carry_q;
        error_d  = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    sub_d    = in_sub;
                    result_d = '0;
                    idx_d    = '0;
                    c_d      = in_sub;
                    carry_d  = 1'b0;
                    error_d  = has_bad_digit(in_a) | has_bad_digit(in_b);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q)*4 +: 4] = dig_out;
                c_d   = dig_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    carry_d = error_q ? 1'b0 : dig_cout;
                    // A bad operand digit voids the whole result
                    if (error_q) begin
                        result_d = '0;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            error_q  <= error_d;
        end
    end

    assign out_busy   = (state_q == ST_RUN);
    assign out_done   = (state_q == ST_DONE);
    assign out_result = result_q;
    assign out_carry  = carry_q;
    assign out_error  = error_q;
    assign out_state  = state_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: a DIGITS=4 and a DIGITS=1 instance share one
// clock. Expected results come from an integer-arithmetic model of the
// decimal add/subtract rules, queued per accepted operation.
module tb_bcd_serial_adder;

    localparam int D4 = 4;
    localparam int D1 = 1;
    localparam int EW = 66;   // {error, carry, result[63:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              d4_start, d4_sub;
    logic [4*D4-1:0]   d4_a, d4_b;
    logic              d4_busy, d4_done, d4_carry, d4_error;
    logic [4*D4-1:0]   d4_result;
    logic [1:0]        d4_state;

    logic              d1_start, d1_sub;
    logic [4*D1-1:0]   d1_a, d1_b;
    logic              d1_busy, d1_done, d1_carry, d1_error;
    logic [4*D1-1:0]   d1_result;
    logic [1:0]        d1_state;

    bcd_serial_adder #(.DIGITS(D4)) u_dut4 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(d4_start), .in_sub(d4_sub),
        .in_a(d4_a), .in_b(d4_b), .out_busy(d4_busy), .out_done(d4_done),
        .out_result(d4_result), .out_carry(d4_carry), .out_error(d4_error),
        .out_state(d4_state)
    );

    bcd_serial_adder #(.DIGITS(D1)) u_dut1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(d1_start), .in_sub(d1_sub),
        .in_a(d1_a), .in_b(d1_b), .out_busy(d1_busy), .out_done(d1_done),
        .out_result(d1_result), .out_carry(d1_carry), .out_error(d1_error),
        .out_state(d1_state)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic longint unsigned bcd_to_int(input logic [63:0] v, input int nd);
        longint unsigned r;
        r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] int_to_bcd(input longint unsigned v, input int nd);
        logic [63:0] r;
        longint unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                            input bit sub, input int nd);
        bit bad;
        longint unsigned av, bv, m, res;
        bit cy;
        bad = 1'b0;
        for (int i = 0; i < nd; i++) begin
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        if (bad) return {1'b1, 1'b0, 64'd0};
        av = bcd_to_int(a, nd);
        bv = bcd_to_int(b, nd);
        m  = pow10(nd);
        if (!sub) begin
            res = (av + bv) % m;
            cy  = (av + bv) >= m;
        end else if (av >= bv) begin
            res = av - bv;
            cy  = 1'b1;
        end else begin
            res = m - (bv - av);
            cy  = 1'b0;
        end
        return {1'b0, cy, int_to_bcd(res, nd)};
    endfunction

    // ---------------- driver tasks ----------------
    function automatic logic [63:0] rand_bcd(input int nd, input bit allow_bad);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nd; i++) begin
            if (allow_bad && $urandom_range(0, 7) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Runs one operation on the selected instance (wide=1 -> DIGITS=4) and
    // checks busy/done timing plus the final result against the model.
    // With repulse set, a second start with other operands is driven mid-run.
    task automatic run_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                          input bit sub, input bit repulse, input string tag);
        int nd;
        logic [EW-1:0] exp;
        logic busy, done, cy, err;
        logic [63:0] res;
        nd = wide ? D4 : D1;
        @(negedge clk);
        if (wide) begin d4_a = a[4*D4-1:0]; d4_b = b[4*D4-1:0]; d4_sub = sub; d4_start = 1'b1; end
        else      begin d1_a = a[4*D1-1:0]; d1_b = b[4*D1-1:0]; d1_sub = sub; d1_start = 1'b1; end
        exp_q.push_back(ref_op(a, b, sub, nd));
        @(posedge clk);  // accepting edge
        #1;
        d4_start = 1'b0;
        d1_start = 1'b0;
        for (int i = 0; i < nd; i++) begin
            @(negedge clk);
            busy = wide ? d4_busy : d1_busy;
            done = wide ? d4_done : d1_done;
            check({tag, ".busy"}, 64'(busy), 64'd1);
            check({tag, ".early_done"}, 64'(done), 64'd0);
            if (repulse && i == 0) begin
                d4_a = ~d4_a; d4_b = 16'h0001; d4_sub = ~d4_sub; d4_start = 1'b1;
            end else begin
                d4_start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        d4_start = 1'b0;
        busy = wide ? d4_busy : d1_busy;
        done = wide ? d4_done : d1_done;
        res  = wide ? 64'(d4_result) : 64'(d1_result);
        cy   = wide ? d4_carry : d1_carry;
        err  = wide ? d4_error : d1_error;
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, ".exp_q_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, ".result"}, res, exp[63:0]);
            check({tag, ".carry"}, 64'(cy), 64'(exp[64]));
            check({tag, ".error"}, 64'(err), 64'(exp[65]));
            // One cycle later: back in IDLE, outputs held
            @(negedge clk);
            done = wide ? d4_done : d1_done;
            res  = wide ? 64'(d4_result) : 64'(d1_result);
            check({tag, ".done_one_cycle"}, 64'(done), 64'd0);
            check({tag, ".result_hold"}, res, exp[63:0]);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen_done;
        logic [63:0] ra, rb;
        d4_start = 1'b0; d4_sub = 1'b0; d4_a = '0; d4_b = '0;
        d1_start = 1'b0; d1_sub = 1'b0; d1_a = '0; d1_b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy",   64'(d4_busy),   64'd0);
        check("rst.done",   64'(d4_done),   64'd0);
        check("rst.result", 64'(d4_result), 64'd0);
        check("rst.carry",  64'(d4_carry),  64'd0);
        check("rst.error",  64'(d4_error),  64'd0);
        rst_n = 1'b1;

        // Directed cases
        run_op(1'b1, 64'h1234, 64'h5678, 1'b0, 1'b0, "add_1234_5678");
        run_op(1'b1, 64'h9999, 64'h0001, 1'b0, 1'b0, "add_9999_0001");
        run_op(1'b1, 64'h0500, 64'h0123, 1'b1, 1'b0, "sub_0500_0123");
        run_op(1'b1, 64'h0123, 64'h0500, 1'b1, 1'b0, "sub_0123_0500");
        run_op(1'b1, 64'h12A4, 64'h0001, 1'b0, 1'b0, "bad_digit");
        run_op(1'b1, 64'h4321, 64'h1111, 1'b0, 1'b1, "repulse");
        run_op(1'b1, 64'h0777, 64'h0777, 1'b1, 1'b0, "sub_equal");
        run_op(1'b0, 64'h9,    64'h9,    1'b0, 1'b0, "d1_add_9_9");
        run_op(1'b0, 64'h3,    64'h7,    1'b1, 1'b0, "d1_sub_3_7");

        // Reset in the middle of a run
        @(negedge clk);
        d4_a = 16'h5555; d4_b = 16'h4444; d4_sub = 1'b0; d4_start = 1'b1;
        @(posedge clk);
        #1 d4_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.busy",   64'(d4_busy),   64'd0);
        check("midrst.done",   64'(d4_done),   64'd0);
        check("midrst.result", 64'(d4_result), 64'd0);
        check("midrst.carry",  64'(d4_carry),  64'd0);
        check("midrst.error",  64'(d4_error),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d4_done) seen_done = 1'b1;
        end
        check("midrst.no_done", 64'(seen_done), 64'd0);
        run_op(1'b1, 64'h0001, 64'h0002, 1'b0, 1'b0, "post_rst_add");

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd(D4, 1'b1);
            rb = rand_bcd(D4, 1'b1);
            run_op(1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), "rand4");
        end
        for (int n = 0; n < 15; n++) begin
            ra = rand_bcd(D1, 1'b1);
            rb = rand_bcd(D1, 1'b1);
            run_op(1'b0, ra, rb, 1'($urandom_range(0, 1)), 1'b0, "rand1");
        end

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
